// File: rtl/pixel_window_cache.sv
// WIN x WIN per-channel pixel neighbourhood cache centred on the requested pixel.
// Columns come from a pipelined line-buffer read port; off-line columns are replicated or zeroed.
module pixel_window_cache #(
    parameter int WIN       = 3,
    parameter int NCH       = 3,
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int LINE_W    = 240,
    parameter int RD_LAT    = 1,
    parameter int EDGE_MODE = 0
) (
    input  logic                      pxlClk,
    input  logic                      rst,
    input  logic [AW-1:0]             curPxlCnt,
    input  logic                      lineChange,
    input  logic [WIN*NCH*DW-1:0]     colIn,
    output logic [AW-1:0]             rdAddr,
    output logic                      rdEn,
    output logic [WIN*WIN*NCH*DW-1:0] win,
    output logic [AW-1:0]             centerPxl,
    output logic                      valid,
    output logic                      busy,
    output logic                      overrun,
    output logic [1:0]                fsm_state
);

    localparam int HALF = WIN / 2;
    localparam int CW   = WIN * NCH * DW;
    localparam int KW   = $clog2(WIN + 1);
    localparam int IW   = AW + 2;
    localparam logic signed [IW-1:0] HALF_S = IW'(HALF);
    localparam logic signed [IW-1:0] STEP_S = IW'(HALF + 1);
    localparam logic signed [IW-1:0] LAST_S = IW'(LINE_W - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, STEP} state_t;

    state_t        state;
    logic [CW-1:0] cols [WIN];
    logic [AW-1:0] fill_c;
    logic [AW-1:0] prev_cur;
    logic [KW-1:0] issue_k;

    // Stage 0 is the issue itself; stage RD_LAT lines up with the returning colIn.
    logic          pipe_v   [RD_LAT+1];
    logic [KW-1:0] pipe_k   [RD_LAT+1];
    logic          pipe_oor [RD_LAT+1];

    logic                 cur_in_range;
    logic                 start_fill;
    logic                 advance;
    logic                 do_issue;
    logic                 issue_oor;
    logic [AW-1:0]        fill_target;
    logic [AW-1:0]        issue_addr;
    logic [KW-1:0]        issue_slot;
    logic signed [IW-1:0] issue_idx;
    logic [CW-1:0]        land_data;

    assign rdEn      = pipe_v[0];
    assign fsm_state = state;

    always_comb begin
        cur_in_range = ({1'b0, curPxlCnt} < (AW+1)'(LINE_W));
        start_fill   = 1'b0;
        advance      = 1'b0;
        fill_target  = fill_c;
        if (lineChange) begin
            start_fill  = 1'b1;
            fill_target = '0;
        end else if (state == RUN && cur_in_range && curPxlCnt != centerPxl) begin
            if ({1'b0, curPxlCnt} == {1'b0, centerPxl} + 1'b1) begin
                advance = 1'b1;
            end else begin
                start_fill  = 1'b1;
                fill_target = curPxlCnt;
            end
        end

        do_issue   = 1'b1;
        issue_slot = '0;
        issue_idx  = $signed({2'b00, fill_target}) - HALF_S;
        if (start_fill) begin
            issue_slot = '0;
        end else if (advance) begin
            issue_slot = KW'(WIN - 1);
            issue_idx  = $signed({2'b00, centerPxl}) + STEP_S;
        end else if (state == FILL && issue_k < KW'(WIN)) begin
            issue_slot = issue_k;
            issue_idx  = $signed({2'b00, fill_c}) - HALF_S + $signed(IW'(issue_k));
        end else begin
            do_issue = 1'b0;
        end

        // Clamping the address is what makes replication work; the tag is only honoured in zero mode.
        issue_oor  = 1'b0;
        issue_addr = issue_idx[AW-1:0];
        if (issue_idx[IW-1]) begin
            issue_addr = '0;
            issue_oor  = 1'b1;
        end else if (issue_idx > LAST_S) begin
            issue_addr = AW'(LINE_W - 1);
            issue_oor  = 1'b1;
        end
        if (EDGE_MODE == 0) issue_oor = 1'b0;

        land_data = pipe_oor[RD_LAT] ? '0 : colIn;
    end

    always_comb begin
        win = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int k = 0; k < WIN; k++) begin
                win[((r*WIN+k)*NCH*DW) +: NCH*DW] = cols[k][(r*NCH*DW) +: NCH*DW];
            end
        end
    end

    always_ff @(posedge pxlClk) begin
        if (rst) begin
            state     <= IDLE;
            rdAddr    <= '0;
            centerPxl <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            fill_c    <= '0;
            prev_cur  <= '0;
            issue_k   <= '0;
            for (int k = 0; k < WIN; k++) cols[k] <= '0;
            for (int j = 0; j <= RD_LAT; j++) begin
                pipe_v[j]   <= 1'b0;
                pipe_k[j]   <= '0;
                pipe_oor[j] <= 1'b0;
            end
        end else begin
            prev_cur <= curPxlCnt;
            if (busy && curPxlCnt != prev_cur) overrun <= 1'b1;

            pipe_v[0]   <= do_issue;
            pipe_k[0]   <= issue_slot;
            pipe_oor[0] <= issue_oor;
            if (do_issue) rdAddr <= issue_addr;
            // A line change kills every read already in flight.
            for (int j = 1; j <= RD_LAT; j++) begin
                pipe_v[j]   <= pipe_v[j-1] && !lineChange;
                pipe_k[j]   <= pipe_k[j-1];
                pipe_oor[j] <= pipe_oor[j-1];
            end

            if (start_fill) begin
                state   <= FILL;
                fill_c  <= fill_target;
                issue_k <= KW'(1);
                busy    <= 1'b1;
                valid   <= 1'b0;
            end else if (advance) begin
                state <= STEP;
                busy  <= 1'b1;
            end else begin
                if (state == FILL && do_issue) issue_k <= issue_k + KW'(1);
                if (pipe_v[RD_LAT]) begin
                    if (state == FILL) begin
                        cols[pipe_k[RD_LAT]] <= land_data;
                        if (pipe_k[RD_LAT] == KW'(WIN - 1)) begin
                            state     <= RUN;
                            busy      <= 1'b0;
                            valid     <= 1'b1;
                            centerPxl <= fill_c;
                        end
                    end else if (state == STEP) begin
                        // Shift and centre update share one edge so the window never looks half-moved.
                        for (int k = 0; k < WIN - 1; k++) cols[k] <= cols[k+1];
                        cols[WIN-1] <= land_data;
                        centerPxl   <= centerPxl + 1'b1;
                        busy        <= 1'b0;
                        state       <= RUN;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_window_cache.sv
// Bench for pixel_window_cache: three instances (replicate, zero-fill, 5x5 with 3-cycle reads)
// behind a behavioural line buffer; a monitor pops expected windows as the DUTs present them.
module tb_pixel_window_cache;

    localparam int EW = 224;

    logic pxlClk = 1'b0;
    logic rst    = 1'b1;
    always #5 pxlClk = ~pxlClk;

    logic [7:0]   cur01 = 8'd0;
    logic [7:0]   cur2  = 8'd0;
    logic         lc01  = 1'b0;
    logic         lc2   = 1'b0;
    logic [71:0]  col0, col1;
    logic [39:0]  col2;
    logic [7:0]   ra0, ra1, ra2, cp0, cp1, cp2;
    logic         re0, re1, re2, v0, v1, v2, b0, b1, b2, ov0, ov1, ov2;
    logic [215:0] w0, w1;
    logic [199:0] w2;
    logic [1:0]   st0, st1, st2;

    logic [EW-1:0] q0[$];
    logic [EW-1:0] q1[$];
    logic [EW-1:0] q2[$];
    int n_checks = 0;
    int n_fail   = 0;

    pixel_window_cache #(.EDGE_MODE(0)) d0 (
        .pxlClk(pxlClk), .rst(rst), .curPxlCnt(cur01), .lineChange(lc01), .colIn(col0),
        .rdAddr(ra0), .rdEn(re0), .win(w0), .centerPxl(cp0), .valid(v0), .busy(b0),
        .overrun(ov0), .fsm_state(st0));

    pixel_window_cache #(.EDGE_MODE(1)) d1 (
        .pxlClk(pxlClk), .rst(rst), .curPxlCnt(cur01), .lineChange(lc01), .colIn(col1),
        .rdAddr(ra1), .rdEn(re1), .win(w1), .centerPxl(cp1), .valid(v1), .busy(b1),
        .overrun(ov1), .fsm_state(st1));

    pixel_window_cache #(.WIN(5), .NCH(1), .RD_LAT(3), .EDGE_MODE(0)) d2 (
        .pxlClk(pxlClk), .rst(rst), .curPxlCnt(cur2), .lineChange(lc2), .colIn(col2),
        .rdAddr(ra2), .rdEn(re2), .win(w2), .centerPxl(cp2), .valid(v2), .busy(b2),
        .overrun(ov2), .fsm_state(st2));

    // Line buffer: sample (row r, channel c) of column a reads back as a + r*NCH + c.
    logic [7:0] ap0 = 8'd0;
    logic [7:0] ap1 = 8'd0;
    logic [7:0] ap2 [3] = '{8'd0, 8'd0, 8'd0};

    always @(posedge pxlClk) begin
        ap0    <= ra0;
        ap1    <= ra1;
        ap2[0] <= ra2;
        ap2[1] <= ap2[0];
        ap2[2] <= ap2[1];
    end

    always_comb begin
        col0 = '0;
        col1 = '0;
        col2 = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                col0[((r*3+c)*8) +: 8] = ap0 + 8'(r*3 + c);
                col1[((r*3+c)*8) +: 8] = ap1 + 8'(r*3 + c);
            end
        end
        for (int r = 0; r < 5; r++) col2[(r*8) +: 8] = ap2[2] + 8'(r);
    end

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Column list given by pixel index, -1 meaning an all-zero column.
    function automatic logic [215:0] mk_win(input int wn, input int nc,
                                            input int k0, input int k1, input int k2,
                                            input int k3, input int k4);
        logic [215:0] w;
        int ks[5];
        ks[0] = k0; ks[1] = k1; ks[2] = k2; ks[3] = k3; ks[4] = k4;
        w = '0;
        for (int r = 0; r < wn; r++)
            for (int k = 0; k < wn; k++)
                for (int c = 0; c < nc; c++)
                    if (ks[k] >= 0) w[(((r*wn+k)*nc+c)*8) +: 8] = 8'(ks[k] + r*nc + c);
        return w;
    endfunction

    task automatic push(input int which, input int c, input int k0, input int k1,
                        input int k2, input int k3, input int k4);
        if (which == 2) q2.push_back({8'(c), mk_win(5, 1, k0, k1, k2, k3, k4)});
        else if (which == 1) q1.push_back({8'(c), mk_win(3, 3, k0, k1, k2, 0, 0)});
        else q0.push_back({8'(c), mk_win(3, 3, k0, k1, k2, 0, 0)});
    endtask

    task automatic tick();
        @(posedge pxlClk);
        #1;
    endtask

    task automatic wait_idle(input int which, input int budget);
        int n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            tick();
            n++;
            ok = (which == 2) ? (v2 && !b2) : (v0 && !b0 && v1 && !b1);
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle dut%0d: no valid window within %0d cycles", which, budget);
        end
    endtask

    // A window is presented whenever valid is high and the window or its centre is new.
    task automatic monitor();
        logic pv0, pv1, pv2;
        logic [7:0] pc0, pc1, pc2;
        logic [215:0] pw0, pw1;
        logic [199:0] pw2;
        pv0 = 1'b0; pv1 = 1'b0; pv2 = 1'b0;
        pc0 = '0; pc1 = '0; pc2 = '0;
        pw0 = '0; pw1 = '0; pw2 = '0;
        forever begin
            @(negedge pxlClk);
            if (!rst) begin
                if (v0 && (!pv0 || cp0 != pc0 || w0 != pw0)) begin
                    if (q0.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL mon0 unexpected window: center %0d", cp0);
                    end else check("mon0 window", {cp0, w0}, q0.pop_front());
                end
                if (v1 && (!pv1 || cp1 != pc1 || w1 != pw1)) begin
                    if (q1.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL mon1 unexpected window: center %0d", cp1);
                    end else check("mon1 window", {cp1, w1}, q1.pop_front());
                end
                if (v2 && (!pv2 || cp2 != pc2 || w2 != pw2)) begin
                    if (q2.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL mon2 unexpected window: center %0d", cp2);
                    end else check("mon2 window", {cp2, 16'h0, w2}, q2.pop_front());
                end
            end
            pv0 = v0; pc0 = cp0; pw0 = w0;
            pv1 = v1; pc1 = cp1; pw1 = w1;
            pv2 = v2; pc2 = cp2; pw2 = w2;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("reset win d0", EW'(w0), EW'(0));
            check("reset win d1", EW'(w1), EW'(0));
            check("reset ctl d0", EW'({ra0, re0, cp0, v0, b0, ov0}), EW'(0));
            check("reset ctl d2", EW'({ra2, re2, cp2, v2, b2, ov2, w2}), EW'(0));
        end

        // Initial fill around pixel 0.
        push(0, 0, 0, 0, 1, 0, 0);
        push(1, 0, -1, 0, 1, 0, 0);
        lc01 = 1'b1;
        tick();
        lc01 = 1'b0;
        check("fill T+1 issue", EW'({re0, ra0, v0, b0}), EW'({1'b1, 8'd0, 1'b0, 1'b1}));
        tick();
        check("fill T+2 issue", EW'({re0, ra0}), EW'({1'b1, 8'd0}));
        tick();
        check("fill T+3 issue", EW'({re0, ra0}), EW'({1'b1, 8'd1}));
        tick();
        check("fill T+4 pending", EW'({re0, v0, b0}), EW'(3'b001));
        tick();
        check("fill T+5 valid d0", EW'({v0, b0, cp0}), EW'({2'b10, 8'd0}));
        check("fill T+5 valid d1", EW'({v1, b1, cp1}), EW'({2'b10, 8'd0}));

        // Single-pixel advances.
        for (int s = 1; s <= 2; s++) begin
            push(0, s, s - 1, s, s + 1, 0, 0);
            push(1, s, s - 1, s, s + 1, 0, 0);
            cur01 = 8'(s);
            check("adv A", EW'({v0, b0}), EW'(2'b10));
            tick();
            check("adv A+1", EW'({re0, ra0, b0, v0}), EW'({1'b1, 8'(s + 1), 1'b1, 1'b1}));
            tick();
            check("adv A+2", EW'({b0, v0, cp0}), EW'({2'b11, 8'(s - 1)}));
            tick();
            check("adv A+3", EW'({b0, v0, cp0}), EW'({2'b01, 8'(s)}));
            tick();
            tick();
            check("adv hold valid", EW'({v0, v1}), EW'(2'b11));
        end

        // Right edge.
        push(0, 238, 237, 238, 239, 0, 0);
        push(1, 238, 237, 238, 239, 0, 0);
        cur01 = 8'd238;
        wait_idle(0, 20);
        push(0, 239, 238, 239, 239, 0, 0);
        push(1, 239, 238, 239, -1, 0, 0);
        cur01 = 8'd239;
        tick();
        check("edge clamp d0", EW'({re0, ra0}), EW'({1'b1, 8'd239}));
        check("edge clamp d1", EW'({re1, ra1}), EW'({1'b1, 8'd239}));
        wait_idle(0, 20);

        // Jump 5 -> 100.
        push(0, 5, 4, 5, 6, 0, 0);
        push(1, 5, 4, 5, 6, 0, 0);
        cur01 = 8'd5;
        wait_idle(0, 20);
        push(0, 100, 99, 100, 101, 0, 0);
        push(1, 100, 99, 100, 101, 0, 0);
        cur01 = 8'd100;
        tick();
        check("jump T+1", EW'({v0, re0, ra0}), EW'({2'b01, 8'd99}));
        tick();
        check("jump T+2", EW'({re0, ra0}), EW'({1'b1, 8'd100}));
        tick();
        check("jump T+3", EW'({re0, ra0}), EW'({1'b1, 8'd101}));
        tick();
        check("jump T+4", EW'(v0), EW'(0));
        tick();
        check("jump T+5", EW'({v0, cp0}), EW'({1'b1, 8'd100}));

        // Request moves during a fill.
        check("overrun clear", EW'({ov0, ov1}), EW'(0));
        push(0, 50, 49, 50, 51, 0, 0);
        push(1, 50, 49, 50, 51, 0, 0);
        push(0, 60, 59, 60, 61, 0, 0);
        push(1, 60, 59, 60, 61, 0, 0);
        cur01 = 8'd50;
        tick();
        tick();
        cur01 = 8'd60;
        tick();
        check("overrun set", EW'({ov0, ov1}), EW'(2'b11));
        wait_idle(0, 20);
        wait_idle(0, 20);

        // Line change in the middle of a step.
        push(0, 0, 0, 0, 1, 0, 0);
        push(1, 0, -1, 0, 1, 0, 0);
        cur01 = 8'd61;
        tick();
        check("midstep busy", EW'(b0), EW'(1));
        lc01  = 1'b1;
        cur01 = 8'd0;
        tick();
        lc01 = 1'b0;
        check("midstep restart", EW'({v0, re0, ra0}), EW'({2'b01, 8'd0}));
        wait_idle(0, 20);
        check("midstep center", EW'({cp0, cp1}), EW'(0));
        check("overrun sticky", EW'({ov0, ov1}), EW'(2'b11));

        // 5x5 window, 3-cycle reads, single channel.
        push(2, 0, 0, 0, 0, 1, 2);
        lc2 = 1'b1;
        tick();
        lc2 = 1'b0;
        check("d2 fill T+1", EW'({re2, ra2, b2, v2}), EW'({1'b1, 8'd0, 2'b10}));
        repeat (7) tick();
        check("d2 fill T+8", EW'({v2, b2}), EW'(2'b01));
        tick();
        check("d2 fill T+9", EW'({v2, b2, cp2}), EW'({2'b10, 8'd0}));
        push(2, 5, 3, 4, 5, 6, 7);
        cur2 = 8'd5;
        wait_idle(2, 30);
        push(2, 100, 98, 99, 100, 101, 102);
        cur2 = 8'd100;
        tick();
        check("d2 jump T+1", EW'({v2, re2, ra2}), EW'({2'b01, 8'd98}));
        repeat (7) tick();
        check("d2 jump T+8", EW'(v2), EW'(0));
        tick();
        check("d2 jump T+9", EW'({v2, cp2}), EW'({1'b1, 8'd100}));
        push(2, 101, 99, 100, 101, 102, 103);
        cur2 = 8'd101;
        tick();
        check("d2 adv A+1", EW'({re2, ra2, b2}), EW'({1'b1, 8'd103, 1'b1}));
        repeat (3) tick();
        check("d2 adv A+4", EW'({b2, v2, cp2}), EW'({2'b11, 8'd100}));
        tick();
        check("d2 adv A+5", EW'({b2, v2, cp2}), EW'({2'b01, 8'd101}));
        check("d2 no overrun", EW'(ov2), EW'(0));

        repeat (5) tick();
        check("q0 drained", EW'(q0.size()), EW'(0));
        check("q1 drained", EW'(q1.size()), EW'(0));
        check("q2 drained", EW'(q2.size()), EW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_window_cache.md
Name: pixel_window_cache

Overview:
- Parametrised successor to the fixed 3x3, 3-channel, 8-bit line cache that feeds the image generator.
- Holds a WIN x WIN neighbourhood per colour channel, centred on the pixel the image generator is currently requesting.
- Fetches columns from the line buffer through a pipelined read port with configurable latency, and handles line-edge pixels by replication or zero fill.
- Sits between lineBuffer and the scaler/filter stage, clocked on pxlClk.

Parameters:
WIN, 3, window size (odd, 3..7); HALF = WIN/2
NCH, 3, colour channels
DW, 8, bits per channel sample
AW, 8, pixel index width
LINE_W, 240, pixels per line
RD_LAT, 1, line-buffer read latency in cycles (1..4)
EDGE_MODE, 0, 0 = replicate edge column, 1 = zero out-of-range columns

Ports:
pxlClk  in  1  clock
rst  in  1  synchronous reset, active-high
curPxlCnt  in  AW  pixel index requested by image generator
lineChange  in  1  one-cycle pulse: buffer rows advanced, refill at pixel 0
colIn  in  WIN*NCH*DW  column returned by line buffer; row r, channel c at bits [((r*NCH+c)*DW) +: DW]; row 0 = topmost line
rdAddr  out  AW  column address to line buffer
rdEn  out  1  read issue strobe
win  out  WIN*WIN*NCH*DW  window; row r, column k (0 = leftmost), channel c at [(((r*WIN+k)*NCH+c)*DW) +: DW]
centerPxl  out  AW  pixel index of window centre column
valid  out  1  window complete and coherent
busy  out  1  fetch in progress
overrun  out  1  sticky: curPxlCnt changed while busy

Behaviour:
- Reset: win all zero; rdAddr 0; rdEn 0; centerPxl 0; valid 0; busy 0; overrun 0; state IDLE. Reset mid-fill discards in-flight reads.
- States: IDLE, FILL, RUN, STEP.
  - IDLE -> FILL on lineChange.
  - FILL -> RUN after last column lands.
  - RUN -> STEP on advance; RUN -> FILL on jump.
  - STEP -> RUN after column lands.
- Column index idx maps to rdAddr = clamp(idx, 0, LINE_W-1).
  - EDGE_MODE 0: clamping alone gives replication.
  - EDGE_MODE 1: columns with idx outside [0, LINE_W-1] are written as zero; a per-issue out-of-range tag travels down an RD_LAT-deep pipeline with the read.
- FILL around centre C: issue idx C-HALF .. C+HALF, one per cycle, rdEn high.
  - Trigger sampled in cycle T; issues in cycles T+1..T+WIN.
  - Data for an issue in cycle i is taken from colIn in cycle i+RD_LAT and registered into its column slot.
  - busy high T+1 .. T+WIN+RD_LAT; valid low from T+1; valid high and centerPxl=C from cycle T+WIN+RD_LAT+1.
- RUN with busy low, curPxlCnt compared each cycle. Values >= LINE_W are ignored (blanking).
  - curPxlCnt == centerPxl: hold.
  - curPxlCnt == centerPxl+1 (advance, detected in cycle A): STEP issues idx centerPxl+1+HALF in cycle A+1. In cycle A+RD_LAT+1 the window shifts one column left and the new column enters at k=WIN-1; centerPxl increments in the same edge, visible A+RD_LAT+2. busy high A+1..A+RD_LAT+1; valid stays high (the shift is atomic).
  - Any other in-range value (jump): FILL around curPxlCnt, with valid dropping.
- lineChange has priority over everything. In any state, including mid-FILL or mid-STEP: abort, discard in-flight tags, restart FILL around C=0 on the next cycle.
- overrun: set when curPxlCnt differs from its previous-cycle value while busy; cleared only by rst. The comparison is level-based, so the pending request is re-evaluated once busy falls.
- rdEn low when no issue; rdAddr holds its last value.

Test Plan:
- Reset: hold rst 3 cycles, then release with no lineChange -> valid=0, busy=0, win=0, rdEn never asserted.
- Default params, EDGE_MODE 0, RD_LAT 1, colIn = column address replicated in all samples; lineChange at T -> rdAddr 0,0,1 in T+1..T+3; valid at T+5; win columns = {0,0,1}, centerPxl=0. Repeat with EDGE_MODE 1 -> columns {0(zero),0,1}.
- Sweep curPxlCnt 0->1->2 with 5-cycle hold -> each advance updates win after RD_LAT+2 cycles; columns {0,1,2} then {1,2,3}; valid never drops.
- Right edge: advance to 239 -> rdAddr 239 (clamped from 240); columns {238,239,239} in mode 0, {238,239,0} in mode 1.
- Jump from centre 5 to curPxlCnt=100 -> valid drops; issues 99,100,101; valid after WIN+RD_LAT+1 cycles with centerPxl=100. Repeat with WIN=5, RD_LAT=3, NCH=1.
- Change curPxlCnt during FILL -> overrun=1 and stays set. Pulse lineChange mid-STEP -> refill at 0; stale data never appears in win.
